xz_word_packer: RTL and testbench

- Consumes the 4-state nibble stream produced by the packed-array output stage and repacks it into 16-bit two-state words, laid out as [0:3][0:3], for the downstream multi-input consumer.
- Detects X/Z bits, scrubs them to a known value, and flags every affected word.
- Buffers completed words in a small FIFO behind a valid/ready handshake.
- Keeps a saturating count of all X/Z bits seen.

---
 rtl/xz_word_packer_if.sv | 24 ++
 rtl/xz_word_packer.sv | 94 +++++++++
 tb/tb_xz_word_packer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/xz_word_packer_if.sv
// xz_word_packer_if: nibble-in / word-out handshake bundle for xz_word_packer.
interface xz_word_packer_if #(
  parameter int NIB_W         = 4,
  parameter int NIBS_PER_WORD = 4
);
  localparam int W = NIB_W * NIBS_PER_WORD;
  logic             in_valid;
  logic             in_ready;
  logic [NIB_W-1:0] in_nib;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_word;
  logic [2:0]       out_nibs;
  logic             out_xz;
  modport master (
    output in_valid, in_nib, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_nibs, out_xz
  );
  modport slave (
    input  in_valid, in_nib, in_last, out_ready,
    output in_ready, out_valid, out_word, out_nibs, out_xz
  );
endinterface

// File: rtl/xz_word_packer.sv
// xz_word_packer: scrubs X/Z bits from a 4-state nibble stream, packs nibbles
// MSB-first into two-state words and queues them in a fall-through FIFO.
module xz_word_packer #(
  parameter int   NIB_W         = 4,
  parameter int   NIBS_PER_WORD = 4,
  parameter int   FIFO_DEPTH    = 4,
  parameter logic SCRUB_VAL     = 1'b0,
  parameter int   CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  xz_word_packer_if.slave    bus,
  input  logic               clr_count,
  output logic [CNT_W-1:0]   xz_count
);
  localparam int W  = NIB_W * NIBS_PER_WORD;
  localparam int IW = $clog2(NIBS_PER_WORD);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = $clog2(NIB_W + 1);
  localparam int SW = CNT_W + 1;

  logic [W-1:0]     asm_word, word_nxt;
  logic [IW-1:0]    idx;
  logic             flag;
  logic [NIB_W-1:0] xz_bits, clean;
  logic [XW-1:0]    pop_cnt;
  logic [SW-1:0]    sum;
  logic             accept, done, push, pop;
  logic [W-1:0]     mem_word [FIFO_DEPTH];
  logic [2:0]       mem_nibs [FIFO_DEPTH];
  logic             mem_xz   [FIFO_DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count, count_nxt;

  // Case-inequality is the only way to see X/Z; anything not exactly 0/1 is scrubbed.
  always_comb begin
    xz_bits = '0;
    clean   = '0;
    pop_cnt = '0;
    for (int i = 0; i < NIB_W; i++) begin
      xz_bits[i] = (bus.in_nib[i] !== 1'b0) && (bus.in_nib[i] !== 1'b1);
      clean[i]   = xz_bits[i] ? SCRUB_VAL : bus.in_nib[i];
      pop_cnt    = pop_cnt + XW'(xz_bits[i]);
    end
  end

  assign accept    = bus.in_valid && bus.in_ready;
  assign done      = (int'(idx) == NIBS_PER_WORD - 1) || bus.in_last;
  assign push      = accept && done;
  assign pop       = bus.out_valid && bus.out_ready;
  assign word_nxt  = asm_word | (W'(clean) << (NIB_W * (NIBS_PER_WORD - 1 - int'(idx))));
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign sum       = {1'b0, xz_count} + SW'(pop_cnt);

  assign bus.out_valid = count != '0;
  assign bus.out_word  = bus.out_valid ? mem_word[rptr] : '0;
  assign bus.out_nibs  = bus.out_valid ? mem_nibs[rptr] : '0;
  assign bus.out_xz    = bus.out_valid && mem_xz[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word     <= '0;
      idx          <= '0;
      flag         <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.in_ready <= 1'b0;
      xz_count     <= '0;
    end else begin
      bus.in_ready <= count_nxt != CW'(FIFO_DEPTH);
      if (accept) begin
        asm_word <= done ? '0 : word_nxt;
        idx      <= done ? '0 : idx + 1'b1;
        flag     <= !done && (flag || |xz_bits);
      end
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_nxt;
      if (clr_count) xz_count <= '0;
      else if (accept) xz_count <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  // Storage needs no reset: reads are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_word[wptr] <= word_nxt;
      mem_nibs[wptr] <= 3'(idx) + 3'd1;
      mem_xz[wptr]   <= flag || |xz_bits;
    end
  end
endmodule

// File: tb/tb_xz_word_packer.sv
// tb_xz_word_packer: directed stimulus with a queued scoreboard and an
// independent monitor that checks every popped word.
module tb_xz_word_packer;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       clr_count = 0;
  logic [7:0] xz_count;

  always #5 clk = ~clk;

  xz_word_packer_if #(.NIB_W(4), .NIBS_PER_WORD(4)) bus ();
  xz_word_packer dut (.clk(clk), .rst_n(rst_n), .bus(bus), .clr_count(clr_count), .xz_count(xz_count));

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  nibs;
    logic        xz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_asm;
  int          m_idx;
  logic        m_flag;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model of one accepted nibble; a bit is X/Z if it is neither 0 nor 1.
  task automatic model(input logic [3:0] n, input logic l);
    logic [3:0] m, c;
    int s;
    for (int i = 0; i < 4; i++) begin
      m[i] = (n[i] !== 1'b0) && (n[i] !== 1'b1);
      c[i] = m[i] ? 1'b0 : n[i];
    end
    m_asm  = m_asm | (16'(c) << (12 - 4 * m_idx));
    m_flag = m_flag | (|m);
    s      = m_cnt + $countones(m);
    m_cnt  = clr_count ? 0 : (s > 255 ? 255 : s);
    if (m_idx == 3 || l) begin
      sb.push_back('{m_asm, 3'(m_idx + 1), m_flag});
      m_asm = 0; m_idx = 0; m_flag = 0;
    end else m_idx++;
  endtask

  task automatic send(input logic [3:0] n, input logic l);
    int t = 0;
    bus.in_valid = 1; bus.in_nib = n; bus.in_last = l;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout nibble %b never accepted", n);
    end else begin
      @(posedge clk);
      model(n, l);
    end
    @(negedge clk);
    bus.in_valid = 0; bus.in_last = 0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.out_ready = v;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t a, e;
      a = '{bus.out_word, bus.out_nibs, bus.out_xz};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got word %h nibs %0d xz %b want none", a.word, a.nibs, a.xz);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL popped_word got word %h nibs %0d xz %b want word %h nibs %0d xz %b",
                   a.word, a.nibs, a.xz, e.word, e.nibs, e.xz);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_nib = 0; bus.in_last = 0; bus.out_ready = 0;
    m_asm = 0; m_idx = 0; m_flag = 0; m_cnt = 0;
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_word", bus.out_word, 0);
    check("rst_out_nibs", bus.out_nibs, 0);
    check("rst_out_xz", bus.out_xz, 0);
    check("rst_xz_count", xz_count, 0);
    @(negedge clk);
    rst_n = 1;
    check("in_ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    check("in_ready_after_edge", bus.in_ready, 1);
    bus.out_ready = 1;

    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_word", bus.out_word, 16'h1234);
    check("lat_out_nibs", bus.out_nibs, 4);
    check("lat_out_xz", bus.out_xz, 0);
    check("clean_xz_count", xz_count, 0);

    send(4'b1x10, 0); send(4'bxxxx, 0); send(4'h0, 0); send(4'hF, 0);
    repeat (2) @(negedge clk);
    check("xz_count_after_scrub", xz_count, 32'(m_cnt));

    send(4'hA, 0); send(4'hB, 1);
    check("short_word", bus.out_word, 16'hAB00);
    check("short_nibs", bus.out_nibs, 2);
    send(4'hC, 0); send(4'hD, 0); send(4'hE, 0); send(4'hF, 0);
    repeat (3) @(negedge clk);
    check("drained", bus.out_valid, 0);

    bus.out_ready = 0;
    for (int i = 0; i < 16; i++) send(4'(i), 0);
    check("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1; bus.in_nib = 4'h9; bus.in_last = 1;
    repeat (3) begin
      @(negedge clk);
      check("held_in_ready", bus.in_ready, 0);
      check("held_head_word", bus.out_word, 16'h0123);
    end
    set_ready(1);
    send(4'h9, 1);
    repeat (6) @(negedge clk);
    check("drained_after_full", bus.out_valid, 0);

    for (int i = 0; i < 64; i++) send(4'bxxxx, 0);
    check("xz_count_saturated", xz_count, 32'(m_cnt));
    clr_count = 1;
    send(4'bxxxx, 0);
    clr_count = 0;
    check("xz_count_cleared", xz_count, 0);

    send(4'bxxxx, 0); send(4'h3, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_xz_count", xz_count, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
    #1 rst_n = 1;
    m_asm = 0; m_idx = 0; m_flag = 0; m_cnt = 0;
    @(negedge clk);
    send(4'h5, 0); send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
    check("post_rst_word", bus.out_word, 16'h5678);
    check("post_rst_nibs", bus.out_nibs, 4);
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
